// File: rtl/th_disp_fmt_if.sv
// Sensor-to-display bus for th_disp_fmt.
// The master side delivers DHT11 frames and the page mode.
// The slave side returns the packed seg_dynamic codes plus their status strobes.
interface th_disp_fmt_if #(
  parameter int DIGITS = 6
);
  logic [39:0]         frame_data;
  logic                frame_valid;
  logic [1:0]          mode_sel;
  logic [5*DIGITS-1:0] dis;
  logic                disp_valid;
  logic                busy;

  modport master (
    output frame_data, frame_valid, mode_sel,
    input  dis, disp_valid, busy
  );

  modport slave (
    input  frame_data, frame_valid, mode_sel,
    output dis, disp_valid, busy
  );
endinterface

// File: rtl/th_disp_fmt.sv
// th_disp_fmt: DHT11 frame to seg_dynamic code formatter.
// Each frame is checksum-validated and the selected reading is converted to BCD
// by a sequential double-dabble engine (one bit per cycle). The result is then
// laid out as sign, digits, decimal point and page tag.
// Optional feature macro TH_ERR_CNT_EN adds the err_cnt port and the
// consecutive-bad-frame error page.
module th_disp_fmt #(
  parameter int DIGITS    = 6,
  parameter int CLK_HZ    = 50_000_000,
  parameter int DWELL_MS  = 2000,
  parameter int ERR_LIMIT = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  th_disp_fmt_if.slave     bus
`ifdef TH_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  // Divide before multiplying so the default 2 s dwell at 50 MHz fits in 32 bits.
  localparam int DWELL_CYC = (CLK_HZ / 1000) * DWELL_MS;
  localparam int CNT_W     = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);

  // Reject parameter sets that the display layout cannot represent.
  if (DIGITS < 6 || DIGITS > 8 || ERR_LIMIT < 1) begin : g_bad_param
    $error("th_disp_fmt: DIGITS must be 6..8 and ERR_LIMIT at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CONV, S_PACK} state_t;

  state_t              state_q, state_d;
  logic [39:0]         work_q, work_d;
  logic                job_frame_q, job_frame_d;
  logic [39:0]         pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic [31:0]         stored_q, stored_d;
  logic                stored_valid_q, stored_valid_d;
  logic                page_q, page_d;
  logic [1:0]          mode_prev_q, mode_prev_d;
  logic                req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          bin_q, bin_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [2:0]          bit_q, bit_d;
  logic [3:0]          frac_q, frac_d;
  logic                neg_q, neg_d;
  logic                tag_q, tag_d;
  logic                err_q, err_d;
  logic [5*DIGITS-1:0] dis_q, dis_d;
  logic                disp_valid_q, disp_valid_d;
`ifdef TH_ERR_CNT_EN
  localparam logic [7:0] ERR_LIM8 = 8'(ERR_LIMIT);
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [7:0]          consec_q, consec_d;
`endif

  logic                req_new;
  logic                go_conv;
  logic                show_err;
  logic [31:0]         src;
  logic [7:0]          int_v;
  logic [7:0]          frac_v;
  logic                neg_v;
  logic [7:0]          sum_v;
  logic [11:0]         adj;
  logic [19:0]         sh;
  logic [5*DIGITS-1:0] pack_dis;
  logic [3:0]          hund, tens, units;

  // Page selection, dwell timing and re-conversion requests from mode changes.
  always_comb begin
    mode_prev_d = bus.mode_sel;
    cnt_d       = '0;
    page_d      = page_q;
    req_new     = 1'b0;
    case (bus.mode_sel)
      2'b00, 2'b01: page_d = bus.mode_sel[0];
      2'b10: begin
        if (mode_prev_q == 2'b10) begin
          if (cnt_q == CNT_LAST) begin
            page_d  = ~page_q;
            req_new = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (bus.mode_sel != mode_prev_q && bus.mode_sel != 2'b11 &&
        (bus.mode_sel != 2'b10 || mode_prev_q == 2'b11)) begin
      req_new = 1'b1;
    end
    req_new = req_new && stored_valid_q;
  end

  // Main sequencer: job intake, checksum, double-dabble conversion and display update.
  always_comb begin
    state_d        = state_q;
    work_d         = work_q;
    job_frame_d    = job_frame_q;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    stored_d       = stored_q;
    stored_valid_d = stored_valid_q;
    req_d          = req_q | req_new;
    bin_d          = bin_q;
    bcd_d          = bcd_q;
    bit_d          = bit_q;
    frac_d         = frac_q;
    neg_d          = neg_q;
    tag_d          = tag_q;
    err_d          = err_q;
    dis_d          = dis_q;
    disp_valid_d   = 1'b0;
    go_conv        = 1'b0;
    show_err       = 1'b0;
`ifdef TH_ERR_CNT_EN
    err_cnt_d      = err_cnt_q;
    consec_d       = consec_q;
`endif

    src = job_frame_q ? work_q[39:8] : stored_q;
    if (page_q) begin
      int_v  = src[15:8];
      frac_v = {1'b0, src[6:0]};
      neg_v  = src[7];
    end else begin
      int_v  = src[31:24];
      frac_v = src[23:16];
      neg_v  = 1'b0;
    end
    sum_v = work_q[39:32] + work_q[31:24] + work_q[23:16] + work_q[15:8];

    adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
    end
    sh = {adj, bin_q} << 1;

    case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          work_d       = pend_q;
          job_frame_d  = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = S_CHECK;
        end else if (bus.frame_valid) begin
          work_d      = bus.frame_data;
          job_frame_d = 1'b1;
          state_d     = S_CHECK;
        end else if (req_q || req_new) begin
          job_frame_d = 1'b0;
          req_d       = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (job_frame_q && sum_v != work_q[7:0]) begin
`ifdef TH_ERR_CNT_EN
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          if (consec_q != 8'hFF) consec_d = consec_q + 8'd1;
          if (consec_d >= ERR_LIM8 && bus.mode_sel != 2'b11) begin
            go_conv  = 1'b1;
            show_err = 1'b1;
          end
`endif
        end else if (job_frame_q) begin
          stored_d       = work_q[39:8];
          stored_valid_d = 1'b1;
`ifdef TH_ERR_CNT_EN
          consec_d       = '0;
`endif
          go_conv        = (bus.mode_sel != 2'b11);
        end else begin
          go_conv = stored_valid_q && (bus.mode_sel != 2'b11);
`ifdef TH_ERR_CNT_EN
          if (consec_q >= ERR_LIM8) show_err = 1'b1;
`endif
        end
        if (go_conv) begin
          req_d   = req_new;
          bin_d   = int_v;
          bcd_d   = '0;
          bit_d   = '0;
          frac_d  = (frac_v > 8'd9) ? 4'd9 : frac_v[3:0];
          neg_d   = neg_v;
          tag_d   = page_q;
          err_d   = show_err || (neg_v && int_v >= 8'd100);
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        bcd_d = sh[19:8];
        bin_d = sh[7:0];
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_PACK;
      end
      S_PACK: begin
        if (bus.mode_sel != 2'b11) begin
          dis_d        = pack_dis;
          disp_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.frame_valid && (state_q != S_IDLE || pend_valid_q)) begin
      pend_d       = bus.frame_data;
      pend_valid_d = 1'b1;
    end
  end

  // Lay out the converted reading (or the error page) as display codes.
  always_comb begin
    pack_dis = {DIGITS{5'd20}};
    hund     = bcd_q[11:8];
    tens     = bcd_q[7:4];
    units    = bcd_q[3:0];
    if (err_q) begin
      pack_dis[5*(DIGITS-1) +: 5] = 5'd24;
      pack_dis[5*(DIGITS-2) +: 5] = 5'd25;
      pack_dis[5*(DIGITS-3) +: 5] = 5'd25;
    end else begin
      pack_dis[4:0] = {1'b0, frac_q};
      pack_dis[9:5] = {1'b0, units} + 5'd10;
      if (hund != 4'd0) begin
        pack_dis[19:15] = {1'b0, hund};
        pack_dis[14:10] = {1'b0, tens};
        if (neg_q) pack_dis[24:20] = 5'd23;
      end else if (tens != 4'd0) begin
        pack_dis[14:10] = {1'b0, tens};
        if (neg_q) pack_dis[19:15] = 5'd23;
      end else if (neg_q) begin
        pack_dis[14:10] = 5'd23;
      end
      pack_dis[5*(DIGITS-1) +: 5] = tag_q ? 5'd21 : 5'd22;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= S_IDLE;
      work_q         <= '0;
      job_frame_q    <= 1'b0;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      stored_q       <= '0;
      stored_valid_q <= 1'b0;
      page_q         <= 1'b0;
      mode_prev_q    <= 2'b00;
      req_q          <= 1'b0;
      cnt_q          <= '0;
      bin_q          <= '0;
      bcd_q          <= '0;
      bit_q          <= '0;
      frac_q         <= '0;
      neg_q          <= 1'b0;
      tag_q          <= 1'b0;
      err_q          <= 1'b0;
      dis_q          <= {DIGITS{5'd20}};
      disp_valid_q   <= 1'b0;
`ifdef TH_ERR_CNT_EN
      err_cnt_q      <= '0;
      consec_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      job_frame_q    <= job_frame_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      stored_q       <= stored_d;
      stored_valid_q <= stored_valid_d;
      page_q         <= page_d;
      mode_prev_q    <= mode_prev_d;
      req_q          <= req_d;
      cnt_q          <= cnt_d;
      bin_q          <= bin_d;
      bcd_q          <= bcd_d;
      bit_q          <= bit_d;
      frac_q         <= frac_d;
      neg_q          <= neg_d;
      tag_q          <= tag_d;
      err_q          <= err_d;
      dis_q          <= dis_d;
      disp_valid_q   <= disp_valid_d;
`ifdef TH_ERR_CNT_EN
      err_cnt_q      <= err_cnt_d;
      consec_q       <= consec_d;
`endif
    end
  end

  assign bus.dis        = dis_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.busy       = (state_q != S_IDLE);
`ifdef TH_ERR_CNT_EN
  assign err_cnt        = err_cnt_q;
`endif

endmodule
